// File: rtl/seven_seg_anim_scanner.sv
// Multiplexed seven-segment driver. Each digit holds an animated ring pattern.
// The digits are time-multiplexed onto a shared active-low segment bus and a scan index.
module seven_seg_anim_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_W     = 3,
    parameter int SEG_W      = 6,
    parameter int SCAN_DIV   = 65536,
    parameter int STEP_DIV   = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [NUM_DIGITS-1:0] dir_mask,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic                  load,
    input  logic [SCAN_W-1:0]     load_idx,
    input  logic [SEG_W-1:0]      load_pat,
    output logic [7:0]            segout,
    output logic [SCAN_W-1:0]     scanout,
    output logic                  step_pulse
);

    localparam int SCAN_CW = $clog2(SCAN_DIV);
    localparam int STEP_CW = $clog2(STEP_DIV);
    localparam logic [SEG_W-1:0] EVEN_RST = ~SEG_W'(1);
    localparam logic [SEG_W-1:0] ODD_RST  = ~(SEG_W'(1) << (SEG_W - 1));

    logic [SCAN_CW-1:0]                scan_cnt_q, scan_cnt_d;
    logic [STEP_CW-1:0]                step_cnt_q, step_cnt_d;
    logic [SCAN_W-1:0]                 scan_q, scan_d;
    logic [7:0]                        seg_q, seg_d;
    logic                              pulse_q, pulse_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]  ring_q, ring_d;
    logic                              scan_wrap, step_hit;

    // Rotation is done on a doubled copy of the ring, so that SEG_W=1 needs no special case.
    function automatic logic [SEG_W-1:0] rot_left(input logic [SEG_W-1:0] r);
        logic [2*SEG_W-1:0] dbl;
        dbl = {r, r};
        return dbl[2*SEG_W-2 -: SEG_W];
    endfunction

    function automatic logic [SEG_W-1:0] rot_right(input logic [SEG_W-1:0] r);
        logic [2*SEG_W-1:0] dbl;
        dbl = {r, r};
        return dbl[SEG_W -: SEG_W];
    endfunction

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_CW'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_CW'(1);
        scan_d     = scan_q;
        if (scan_wrap) begin
            scan_d = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
        end

        step_hit   = enable && (step_cnt_q == STEP_CW'(STEP_DIV - 1));
        step_cnt_d = step_cnt_q;
        if (enable) begin
            step_cnt_d = step_hit ? '0 : step_cnt_q + STEP_CW'(1);
        end
        pulse_d = step_hit;
    end

    always_comb begin
        ring_d = ring_q;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (step_hit) begin
                unique case (mode)
                    2'b01:   ring_d[d] = dir_mask[d] ? rot_right(ring_q[d]) : rot_left(ring_q[d]);
                    2'b10:   ring_d[d] = rot_left(ring_q[d]);
                    2'b11:   ring_d[d] = rot_right(ring_q[d]);
                    default: ring_d[d] = ring_q[d];
                endcase
            end
            // A load wins over rotation, but only for its own digit.
            if (load && load_idx == SCAN_W'(d)) begin
                ring_d[d] = load_pat;
            end
        end
    end

    // segout looks ahead to the next scan index, so the bus and the index change together.
    always_comb begin
        seg_d = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (scan_d == SCAN_W'(d) && !blank_mask[d]) begin
                seg_d[SEG_W-1:0] = ring_q[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            step_cnt_q <= '0;
            scan_q     <= '0;
            seg_q      <= '1;
            pulse_q    <= 1'b0;
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                ring_q[d] <= (d % 2 == 0) ? EVEN_RST : ODD_RST;
            end
        end else begin
            scan_cnt_q <= scan_cnt_d;
            step_cnt_q <= step_cnt_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
            pulse_q    <= pulse_d;
            ring_q     <= ring_d;
        end
    end

    assign segout     = seg_q;
    assign scanout    = scan_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_seven_seg_anim_scanner.sv
// Bench for seven_seg_anim_scanner: directed scenarios and then random stimulus.
// All outputs are compared every cycle against a cycle-count based reference model.
module tb_seven_seg_anim_scanner;

    localparam int ND   = 4;
    localparam int SW   = 3;
    localparam int SEGW = 6;
    localparam int SD   = 4;
    localparam int STD  = 8;
    localparam int MASK = (1 << SEGW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [1:0]      mode;
    logic [ND-1:0]   dir_mask;
    logic [ND-1:0]   blank_mask;
    logic            load;
    logic [SW-1:0]   load_idx;
    logic [SEGW-1:0] load_pat;
    logic [7:0]      segout;
    logic [SW-1:0]   scanout;
    logic            step_pulse;

    always #5 clk = ~clk;

    seven_seg_anim_scanner #(
        .NUM_DIGITS(ND),
        .SCAN_W    (SW),
        .SEG_W     (SEGW),
        .SCAN_DIV  (SD),
        .STEP_DIV  (STD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .dir_mask  (dir_mask),
        .blank_mask(blank_mask),
        .load      (load),
        .load_idx  (load_idx),
        .load_pat  (load_pat),
        .segout    (segout),
        .scanout   (scanout),
        .step_pulse(step_pulse)
    );

    int errors = 0;
    int checks = 0;

    // The model tracks cycles since release (k) and enabled cycles (e).
    // It derives the scan index and step timing from these two counts by division.
    int unsigned m_ring [ND];
    int unsigned k, e;
    int unsigned exp_seg, exp_scan, exp_pulse;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned rl(input int unsigned v);
        return ((v << 1) | (v >> (SEGW - 1))) & MASK;
    endfunction

    function automatic int unsigned rr(input int unsigned v);
        return ((v >> 1) | ((v & 1) << (SEGW - 1))) & MASK;
    endfunction

    task automatic model_reset();
        k = 0;
        e = 0;
        for (int d = 0; d < ND; d++)
            m_ring[d] = (d % 2 == 0) ? (MASK & ~1) : (MASK & ~(1 << (SEGW - 1)));
        exp_seg = 8'hFF;
        exp_scan = 0;
        exp_pulse = 0;
    endtask

    task automatic tick();
        int unsigned n;
        bit step;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            k++;
            if (enable) e++;
            n = (k / SD) % ND;
            exp_scan = n;
            exp_seg = blank_mask[n] ? 8'hFF : ((8'hFF & ~MASK) | m_ring[n]);
            step = enable && (e % STD == 0);
            exp_pulse = step;
            if (step) begin
                for (int d = 0; d < ND; d++) begin
                    case (mode)
                        2'b01: m_ring[d] = dir_mask[d] ? rr(m_ring[d]) : rl(m_ring[d]);
                        2'b10: m_ring[d] = rl(m_ring[d]);
                        2'b11: m_ring[d] = rr(m_ring[d]);
                        default: ;
                    endcase
                end
            end
            if (load && load_idx < ND) m_ring[load_idx] = load_pat;
        end
        #1;
        check_eq("segout", 32'(segout), exp_seg);
        check_eq("scanout", 32'(scanout), exp_scan);
        check_eq("step_pulse", 32'(step_pulse), exp_pulse);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt;
        bit seen;
        model_reset();
        reset = 1'b0; enable = 1'b0; mode = 2'b00; dir_mask = '0; blank_mask = '0;
        load = 1'b0; load_idx = '0; load_pat = '0;
        run(2);
        check_eq("reset_seg", 32'(segout), 32'hFF);

        // Idle: scanning runs, animation frozen
        reset = 1'b1;
        tick();
        check_eq("release_seg", 32'(segout), 32'hFE);
        run(20);

        // Global rotate left
        enable = 1'b1; mode = 2'b10;
        run(60);

        // Per-digit direction
        mode = 2'b01; dir_mask = 4'b0101;
        run(24);

        // Load coinciding with a step edge
        mode = 2'b10;
        cnt = 0;
        while (((e + 1) % STD) != 0 && cnt < 20) begin tick(); cnt++; end
        check_eq("align_step_bound", 32'(cnt < 20), 32'd1);
        load = 1'b1; load_idx = 3'd2; load_pat = '0;
        tick();
        load = 1'b0;
        check_eq("collision_pulse", 32'(step_pulse), 32'd1);
        cnt = 0;
        while (scanout != 3'd2 && cnt < 20) begin tick(); cnt++; end
        check_eq("slot2_bound", 32'(cnt < 20), 32'd1);
        check_eq("slot2_seg", 32'(segout), 32'hC0);

        // Invalid load index, then blank digit 1
        load = 1'b1; load_idx = 3'd5; load_pat = 6'h15;
        tick();
        load = 1'b0; blank_mask = 4'b0010;
        run(24);
        blank_mask = '0;

        // Mid-run reset: first pulse arrives exactly STEP_DIV cycles after release
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            tick(); cnt++;
            seen = step_pulse;
        end
        check_eq("first_pulse_delay", 32'(cnt), 32'd8);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) != 0);
            enable     = ($urandom_range(0, 3) != 0);
            mode       = 2'($urandom);
            dir_mask   = ND'($urandom);
            blank_mask = ($urandom_range(0, 4) == 0) ? ND'($urandom) : '0;
            load       = ($urandom_range(0, 4) == 0);
            load_idx   = SW'($urandom);
            load_pat   = SEGW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_anim_scanner.md
Name: seven_seg_anim_scanner

Overview:
- Parametrised multiplexed seven-segment driver for the board display.
- Holds one SEG_W-bit ring pattern per digit and animates the rings by rotation, with a per-digit or global direction.
- Time-multiplexes the digits onto a shared active-low segment bus and scan index.
- Sits between the user control logic (buttons/switches, pattern loader) and the 7-SEG pins; replaces the fixed 4-digit rotating-pattern display.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 2..2**SCAN_W.
- SCAN_W, 3: width of scanout.
- SEG_W, 6: ring length; segment bits driven from the ring, range 1..8.
- SCAN_DIV, 65536: clk cycles per digit slot; must be at least 2.
- STEP_DIV, 12500000: clk cycles per animation step; must be at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = step counter runs; 0 = step counter and animation frozen.
- mode  in  2  00 hold; 01 per-digit direction from dir_mask; 10 all rotate left; 11 all rotate right.
- dir_mask  in  NUM_DIGITS  per-digit direction for mode 01; bit d = 1 rotates digit d right, 0 rotates left.
- blank_mask  in  NUM_DIGITS  bit d = 1 forces digit d dark.
- load  in  1  single-cycle write strobe for a digit pattern.
- load_idx  in  SCAN_W  target digit of the write.
- load_pat  in  SEG_W  pattern written; 0 = segment lit.
- segout  out  8  active-low segment bus, registered.
- scanout  out  SCAN_W  current digit index, registered.
- step_pulse  out  1  one-cycle strobe on each animation step, registered.

Behaviour:
- Reset: only sampled at a rising clk edge while reset=0; it overrides every other input.
- Reset values:
  - scan_cnt=0, step_cnt=0, scanout=0, segout=8'hFF, step_pulse=0.
  - Ring d for even d: all ones except bit 0 = 0.
  - Ring d for odd d: all ones except bit SEG_W-1 = 0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 every cycle; it is never gated by enable.
  - At SCAN_DIV-1: scan_cnt returns to 0 and scanout advances by 1.
  - scanout wraps from NUM_DIGITS-1 to 0. Codes at or above NUM_DIGITS never appear.
- Step counter:
  - While enable=1, step_cnt counts 0..STEP_DIV-1.
  - At STEP_DIV-1: step_cnt returns to 0, step_pulse=1 on the next cycle, and the rings update on that same edge.
  - While enable=0, step_cnt holds its value and step_pulse=0.
- Rotation on a step edge:
  - Left: r <= {r[SEG_W-2:0], r[SEG_W-1]}.
  - Right: r <= {r[0], r[SEG_W-1:1]}.
  - Mode 00: step_pulse still fires; rings hold.
  - Mode and dir_mask are sampled on the step edge only.
- Load:
  - load=1 with load_idx < NUM_DIGITS writes load_pat into that ring on the edge.
  - Load has priority over rotation for the target digit only; all other digits still rotate on a coincident step.
  - load_idx >= NUM_DIGITS is ignored.
  - A load is accepted even when enable=0.
- segout, updated every cycle:
  - Let n = next value of scanout and pattern = ring n before this edge's update.
  - If blank_mask[n]=1: segout <= 8'hFF.
  - Otherwise: segout <= {(8-SEG_W) ones, pattern}.
  - So segout always corresponds to the scanout shown in the same cycle; the display has no ghost cycle.
- Latency:
  - A ring change (load or step) is visible on segout one cycle after the edge that changed it, when that digit is selected.
  - A blank_mask change has a latency of 1 cycle.
- Mid-operation reset: all counters, rings and outputs return to reset values on that edge. Partial divider counts are discarded.

Test Plan:
- Reset/idle (NUM_DIGITS=4, SCAN_DIV=4, STEP_DIV=8, enable=0) -> the cycle after release: segout=8'hFE, scanout=0. scanout steps 0,1,2,3,0 every 4 cycles. segout alternates FE, DF, FE, DF. step_pulse never asserts.
- Global rotate (enable=1, mode=10, STEP_DIV=8) -> step_pulse every 8 cycles. Digit 0 goes 111110 -> 111101 -> 111011, and returns to 111110 after 6 steps. Digit 1 goes 011111 -> 111110.
- Per-digit direction (mode=01, dir_mask=4'b0101) -> on one step, digits 0 and 2 rotate right and digits 1 and 3 rotate left. Digit 0 = 011111, digit 1 = 111110.
- Load collision (load=1, load_idx=2, load_pat=6'b000000 on the step edge, mode=10) -> digit 2 = 000000. Digits 0, 1 and 3 are rotated. segout = 8'hC0 in digit-2 slots.
- Invalid load and blanking (load_idx=5, then blank_mask=4'b0010) -> no ring changes. segout=8'hFF whenever scanout=1; other digits unaffected.
- Mid-run reset (reset=0 for 1 cycle at step_cnt=5, scanout=2) -> next cycle: scanout=0, segout=8'hFF, step_pulse=0, rings at reset patterns. The first step_pulse comes 8 cycles after release.
